if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage. It owns the fetch PC and issues reads to a synchronous instruction memory with one-cycle read latency. Returned instructions are buffered in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. Call/Branch/Ret redirects flush the queue and drop any in-flight fetch.

Parameters:
ADDR_W, 16, fetch PC and instruction address width
INSTR_W, 16, instruction width
DEPTH, 4, prefetch queue entries; minimum 2; full throughput needs DEPTH >= 3
RESET_PC, 0, fetch PC value loaded on reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall  in  1  suppresses new fetch issue; dequeue is unaffected
call  in  1  redirect to call_pc; highest priority
call_pc  in  ADDR_W  call target
branch  in  1  redirect to branch_pc; second priority
branch_pc  in  ADDR_W  branch target
ret  in  1  redirect to ret_pc; lowest priority
ret_pc  in  ADDR_W  return target
imem_addr  out  ADDR_W  read address; equals fetch_pc
imem_rd_en  out  1  read strobe
imem_rdata  in  INSTR_W  read data; valid the cycle after rd_en
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc_inc  out  ADDR_W  head fetch address + 1, modulo 2^ADDR_W
occupancy  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- redirect = call | branch | ret. target = call ? call_pc : branch ? branch_pc : ret_pc.
- Reset, asynchronous: fetch_pc=RESET_PC, count=0, rd/wr pointers=0, pend_valid=0. While rst is high: imem_rd_en=0, out_valid=0, occupancy=0.
- Issue is combinational: imem_rd_en = !rst & !stall & !redirect & (count + pend_valid < DEPTH).
  - count is the pre-edge value. A same-cycle dequeue earns no credit.
- On an issue edge: fetch_pc <= fetch_pc+1 (wraps), pend_valid <= 1, pend_pc <= fetch_pc. With no issue and no redirect: pend_valid <= 0.
- Response cycle (pend_valid=1):
  - If !redirect, write {imem_rdata, pend_pc+1} at wr_ptr.
  - If redirect, discard the response.
- Redirect edge: fetch_pc <= target, count <= 0, pointers <= 0, pend_valid <= 0. Redirect overrides stall.
- out_valid = (count != 0) & !redirect. This is the only combinational input-to-output path besides imem_rd_en.
  - The head is driven from rd_ptr.
  - Dequeue on out_valid & out_ready.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Credit rule guarantees the queue never overflows. An enqueue while count==DEPTH is a design error; add an assertion for it.
- Latency: issue at cycle t, data enters the queue at edge t+1, out_valid is high from t+2.
- Steady state: with out_ready held high and DEPTH >= 3, one instruction is delivered per cycle.
- Full with out_ready low: count stays at DEPTH, issue stops, and the head is held stable.
- Stall only blocks issue. A pending response still enqueues and the queue still drains.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_entry_t struct {instr, pc_inc}
  - redirect priority encoding constants (REDIR_NONE / CALL / BRANCH / RET)
- Natural sub-module: sync_fifo (parametrised width and depth, count output), instantiated with width INSTR_W+ADDR_W.
- The redirect mux and the issue/credit logic stay in the top module.

Test Plan:
- Reset release with RESET_PC=0, out_ready=1:
  - imem_addr sequence is 0,1,2,...
  - first out_valid appears 2 cycles after the first rd_en.
  - out_pc_inc sequence is 1,2,3 with out_instr=mem[0],mem[1],mem[2].
- out_ready=0 for 10 cycles, DEPTH=4:
  - occupancy saturates at 4 and rd_en drops.
  - head stays mem[0].
  - after out_ready=1, four consecutive in-order beats, then fetching resumes.
- call=1, branch=1, ret=1 in the same cycle, with call_pc=0x0100, branch_pc=0x0200, ret_pc=0x0300:
  - next imem_addr=0x0100.
  - occupancy=0 the following cycle.
  - first delivered out_pc_inc=0x0101.
- branch to 0x0040 while pend_valid=1:
  - the in-flight instruction never appears at the output.
  - the next delivered entry has out_pc_inc=0x0041.
- fetch_pc=0xFFFF with ADDR_W=16:
  - next issued address is 0x0000.
  - the entry for 0xFFFF carries out_pc_inc=0x0000.
- stall=1 for 3 cycles with 2 entries queued:
  - no rd_en, but the entries drain on out_ready.
  - ret with ret_pc=0x0020 during stall gives imem_addr=0x0020 on the next edge.
- rst asserted mid-stream with 3 entries queued:
  - out_valid=0 and occupancy=0 immediately.
  - after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Queue entry layout and redirect priority encoding.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 16;
    localparam int FETCH_INSTR_W = 16;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc_inc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_CALL   = 2'd1,
        REDIR_BRANCH = 2'd2,
        REDIR_RET    = 2'd3
    } redir_e;

    // Call beats branch beats ret.
    function automatic redir_e redir_sel(
        input logic c,
        input logic b,
        input logic r
    );
        redir_e s;
        s = REDIR_NONE;
        if (c)      s = REDIR_CALL;
        else if (b) s = REDIR_BRANCH;
        else if (r) s = REDIR_RET;
        return s;
    endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Prefetch FIFO with flush and occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sync_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH+1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic             rd_en_i,
    output logic [W-1:0]     rd_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_wr = wr_en_i && !flush_i;
    assign do_rd = rd_en_i && !flush_i;

    // Next pointers and count; a flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_wr && !do_rd) count_d = count_q + CNT_W'(1);
            if (do_rd && !do_wr) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(do_wr && count_q == CNT_W'(DEPTH))
    );

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC, imem issue with credit, prefetch queue.
// Redirects flush the queue and drop the in-flight response.
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter  int               ADDR_W   = 16,
    parameter  int               INSTR_W  = 16,
    parameter  int               DEPTH    = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               call,
    input  logic [ADDR_W-1:0]  call_pc,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  branch_pc,
    input  logic               ret,
    input  logic [ADDR_W-1:0]  ret_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_inc,
    output logic [CNT_W-1:0]   occupancy
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pend_pc_inc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    inflight;
    logic              redirect;
    redir_e            redir;

    assign redirect = call | branch | ret;
    assign redir    = redir_sel(call, branch, ret);

    // Redirect target selection by priority.
    always_comb begin
        target = fetch_pc_q;
        unique case (redir)
            REDIR_CALL:   target = call_pc;
            REDIR_BRANCH: target = branch_pc;
            REDIR_RET:    target = ret_pc;
            default:      target = fetch_pc_q;
        endcase
    end

    // Credit: queued plus in-flight must leave room for one more.
    assign inflight   = (CNT_W+1)'(count) + (CNT_W+1)'(pend_valid_q);
    assign imem_rd_en = !rst && !stall && !redirect &&
                        (inflight < (CNT_W+1)'(DEPTH));
    assign imem_addr  = fetch_pc_q;

    // Fetch PC and pending-response tracking.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = target;
        end else if (imem_rd_en) begin
            fetch_pc_d   = fetch_pc_q + ADDR_W'(1);
            pend_pc_d    = fetch_pc_q;
            pend_valid_d = 1'b1;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign pend_pc_inc = pend_pc_q + ADDR_W'(1);
    assign out_valid   = (count != '0) && !redirect;
    assign occupancy   = count;

    sync_fifo #(
        .W     (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (redirect),
        .wr_en_i   (pend_valid_q && !redirect),
        .wr_data_i ({imem_rdata, pend_pc_inc}),
        .rd_en_i   (out_valid && out_ready),
        .rd_data_o ({out_instr, out_pc_inc}),
        .count_o   (count)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a delivery scoreboard.
// Memory model returns addr ^ 16'hC35A one cycle after a read.
module tb_if_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        call, branch, ret;
    logic [15:0] call_pc, branch_pc, ret_pc;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc_inc;
    logic [2:0]  occupancy;

    int checks = 0;
    int passed = 0;
    int delivered = 0;
    int n0;
    logic [15:0] last_pc_inc = '0;
    fetch_entry_t sb[$];
    fetch_entry_t e;

    if_fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .call       (call),
        .call_pc    (call_pc),
        .branch     (branch),
        .branch_pc  (branch_pc),
        .ret        (ret),
        .ret_pc     (ret_pc),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc_inc (out_pc_inc),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    // Synchronous instruction memory, one-cycle latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_f(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_from(input logic [15:0] pc);
        fetch_entry_t x;
        sb.delete();
        for (int i = 0; i < 200; i++) begin
            x.instr  = mem_f(pc + 16'(i));
            x.pc_inc = pc + 16'(i) + 16'd1;
            sb.push_back(x);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_deliv(input int base, input string tag);
        int k;
        k = 0;
        while (delivered == base && k < 20) begin
            @(negedge clk);
            #4;
            k++;
        end
        chk(tag, 32'(delivered > base), 32'd1);
    endtask

    // Scoreboard: every accepted beat must match the next expected entry.
    always begin
        @(negedge clk);
        #3;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("beat_instr", 32'(out_instr), 32'(e.instr));
                chk("beat_pc_inc", 32'(out_pc_inc), 32'(e.pc_inc));
            end
            delivered++;
            last_pc_inc = out_pc_inc;
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; out_ready = 1'b1;
        call = 1'b0; branch = 1'b0; ret = 1'b0;
        call_pc = '0; branch_pc = '0; ret_pc = '0;

        // Reset state
        cyc(2);
        #1;
        chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);

        // Release, stream in order
        cyc(1);
        rst = 1'b0;
        expect_from(16'h0000);
        #1;
        chk("t0_addr", 32'(imem_addr), 32'h0);
        chk("t0_rd_en", 32'(imem_rd_en), 32'd1);
        cyc(1); #1;
        chk("t1_addr", 32'(imem_addr), 32'h1);
        chk("t1_valid", 32'(out_valid), 32'd0);
        cyc(1); #1;
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_addr", 32'(imem_addr), 32'h2);
        chk("t2_pc_inc", 32'(out_pc_inc), 32'h1);
        cyc(5);

        // Fill with out_ready low from reset
        rst = 1'b1; out_ready = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_occ", 32'(occupancy), 32'd0);
        cyc(1);
        rst = 1'b0;
        expect_from(16'h0000);
        cyc(10); #1;
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_rd_en", 32'(imem_rd_en), 32'd0);
        chk("full_head_instr", 32'(out_instr), 32'(mem_f(16'h0)));
        chk("full_head_pc_inc", 32'(out_pc_inc), 32'h1);
        cyc(1);
        out_ready = 1'b1;
        #1;
        chk("drain0_rd_en", 32'(imem_rd_en), 32'd0);
        cyc(1); #1;
        chk("resume_rd_en", 32'(imem_rd_en), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'h4);
        cyc(4);

        // Simultaneous call/branch/ret: call wins
        call = 1'b1; branch = 1'b1; ret = 1'b1;
        call_pc = 16'h0100; branch_pc = 16'h0200; ret_pc = 16'h0300;
        expect_from(16'h0100);
        #1;
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_rd_en", 32'(imem_rd_en), 32'd0);
        cyc(1);
        call = 1'b0; branch = 1'b0; ret = 1'b0;
        #1;
        chk("call_addr", 32'(imem_addr), 32'h0100);
        chk("call_occ", 32'(occupancy), 32'd0);
        n0 = delivered;
        wait_deliv(n0, "call_deliv_timeout");
        chk("call_first_pc_inc", 32'(last_pc_inc), 32'h0101);
        cyc(2);

        // Branch with a fetch in flight
        branch = 1'b1; branch_pc = 16'h0040;
        expect_from(16'h0040);
        cyc(1);
        branch = 1'b0;
        #1;
        chk("br_addr", 32'(imem_addr), 32'h0040);
        n0 = delivered;
        wait_deliv(n0, "br_deliv_timeout");
        chk("br_first_pc_inc", 32'(last_pc_inc), 32'h0041);
        cyc(2);

        // PC wrap at top of address space
        branch = 1'b1; branch_pc = 16'hFFFE;
        expect_from(16'hFFFE);
        cyc(1);
        branch = 1'b0;
        #1;
        chk("wrap_addr0", 32'(imem_addr), 32'hFFFE);
        cyc(1); #1;
        chk("wrap_addr1", 32'(imem_addr), 32'hFFFF);
        cyc(1); #1;
        chk("wrap_addr2", 32'(imem_addr), 32'h0000);
        cyc(4);

        // Stall with two queued entries; ret during stall
        branch = 1'b1; branch_pc = 16'h0080; out_ready = 1'b0;
        expect_from(16'h0080);
        cyc(1);
        branch = 1'b0;
        cyc(3);
        stall = 1'b1; out_ready = 1'b1;
        n0 = delivered;
        #1;
        chk("stall_occ", 32'(occupancy), 32'd2);
        chk("stall_rd_en0", 32'(imem_rd_en), 32'd0);
        cyc(1); #1;
        chk("stall_rd_en1", 32'(imem_rd_en), 32'd0);
        cyc(1); #1;
        chk("stall_rd_en2", 32'(imem_rd_en), 32'd0);
        cyc(1);
        ret = 1'b1; ret_pc = 16'h0020;
        expect_from(16'h0020);
        #1;
        chk("stall_drained", 32'(delivered - n0), 32'd3);
        cyc(1);
        ret = 1'b0;
        #1;
        chk("ret_addr", 32'(imem_addr), 32'h0020);
        chk("ret_stall_rd_en", 32'(imem_rd_en), 32'd0);
        cyc(1);
        stall = 1'b0; out_ready = 1'b0;
        #1;
        chk("unstall_rd_en", 32'(imem_rd_en), 32'd1);
        chk("unstall_addr", 32'(imem_addr), 32'h0020);

        // Async reset with three entries queued
        cyc(4); #1;
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_occ", 32'(occupancy), 32'd0);
        cyc(2);
        rst = 1'b0; out_ready = 1'b1;
        expect_from(16'h0000);
        #1;
        chk("restart_addr", 32'(imem_addr), 32'h0);
        chk("restart_rd_en", 32'(imem_rd_en), 32'd1);
        n0 = delivered;
        wait_deliv(n0, "restart_deliv_timeout");
        chk("restart_pc_inc", 32'(last_pc_inc), 32'h1);
        cyc(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
